isp8_alu_ctrl: RTL and testbench

Decode/flag/writeback stage paired with the 8-bit ALU: it supplies the ALU's control inputs and consumes its result.
- Accepts 18-bit instructions over a valid/ready handshake and registers them.
- Drives the ALU control inputs: alu_instr, sub, subc, addc, cmp, imi_instr, imi_data.
- Feeds carry_flag back to the ALU.
- Captures dout_alu/cout_alu into the carry and zero flags and issues a one-cycle register-file writeback.
- Sits between the core's issue logic and the register file.

---
 rtl/isp8_alu_ctrl.sv | 169 ++++++++++++++++
 tb/tb_isp8_alu_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/isp8_alu_ctrl.sv
// isp8_alu_ctrl: decode, flag and writeback stage wrapped around the 8-bit ALU.
// Define ISP8_FLAG_SHADOW_EN to add the interrupt flag shadow (irq_save/irq_restore).
module isp8_alu_ctrl #(
   parameter logic [1:0] FLAG_RESET = 2'b00,
   parameter int         RD_WIDTH   = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [17:0]         instr,
   input  logic                instr_valid,
   output logic                instr_ready,
   input  logic                hold,
   output logic [17:0]         alu_instr,
   output logic                sub,
   output logic                subc,
   output logic                addc,
   output logic                cmp,
   output logic                imi_instr,
   output logic [7:0]          imi_data,
   output logic                carry_flag,
   output logic                zero_flag,
   input  logic [7:0]          dout_alu,
   input  logic                cout_alu,
   output logic                wb_en,
   output logic [RD_WIDTH-1:0] wb_addr,
   output logic [7:0]          wb_data,
   input  logic                irq_save,
   input  logic                irq_restore
);
   localparam logic [17:0] INSTR_NONE = 18'h3FFFF;

   logic                rst_q_r;
   logic [17:0]         alu_instr_r;
   logic                sub_r, subc_r, addc_r, cmp_r, imi_instr_r;
   logic [7:0]          imi_data_r;
   logic [1:0]          flags_r;
   logic                wb_en_r;
   logic [RD_WIDTH-1:0] wb_addr_r;
   logic [7:0]          wb_data_r;

   logic                dec_sub_s, dec_subc_s, dec_addc_s, dec_cmp_s, dec_imi_s;
   logic                d_load_s, d_alu_s, d_flag_only_s, w_fire_s;
   logic [1:0]          w_flags_s, flags_next_s;

   assign instr_ready = ~rst_q_r & ~hold;
   assign alu_instr   = alu_instr_r;
   assign sub         = sub_r;
   assign subc        = subc_r;
   assign addc        = addc_r;
   assign cmp         = cmp_r;
   assign imi_instr   = imi_instr_r;
   assign imi_data    = imi_data_r;
   assign zero_flag   = flags_r[1];
   assign carry_flag  = flags_r[0];
   assign wb_en       = wb_en_r;
   assign wb_addr     = wb_addr_r;
   assign wb_data     = wb_data_r;

   // Decode the incoming word into ALU select lines by instruction class.
   always_comb begin
      dec_sub_s  = 1'b0;
      dec_subc_s = 1'b0;
      dec_addc_s = 1'b0;
      dec_cmp_s  = 1'b0;
      dec_imi_s  = 1'b0;
      case (instr[17:14])
         4'b0000: begin dec_sub_s  = 1'b1; dec_imi_s = instr[13]; end
         4'b0001: begin dec_subc_s = 1'b1; dec_imi_s = instr[13]; end
         4'b0010: begin dec_imi_s  = instr[13]; end
         4'b0011: begin dec_addc_s = 1'b1; dec_imi_s = instr[13]; end
         4'b0100, 4'b0101, 4'b0110, 4'b0111: begin dec_imi_s = instr[13]; end
         4'b1000: begin dec_cmp_s  = 1'b1; dec_imi_s = instr[13]; end
         4'b1001: begin dec_imi_s  = instr[13]; end
         default: begin dec_imi_s  = 1'b0; end
      endcase
   end

   // An invalid D stage holds INSTR_NONE, so it naturally decodes as non-ALU.
   always_comb begin
      d_load_s      = instr_valid & instr_ready;
      d_alu_s       = (alu_instr_r[17:16] != 2'b11);
      d_flag_only_s = (alu_instr_r[17:15] == 3'b100);
      w_fire_s      = d_alu_s & ~hold;
      if (w_fire_s) begin
         w_flags_s = {(dout_alu == 8'h00), cout_alu};
      end else begin
         w_flags_s = flags_r;
      end
   end

`ifdef ISP8_FLAG_SHADOW_EN
   logic [1:0] shadow_r, shadow_next_s;

   // Restore overrides both a same-edge W update and a same-edge save.
   always_comb begin
      shadow_next_s = shadow_r;
      flags_next_s  = w_flags_s;
      if (hold) begin
         shadow_next_s = shadow_r;
      end else if (irq_restore) begin
         flags_next_s = shadow_r;
      end else if (irq_save) begin
         shadow_next_s = w_flags_s;
      end else begin
         shadow_next_s = shadow_r;
      end
   end

   // Shadow flag register.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_r <= FLAG_RESET;
      end else begin
         shadow_r <= shadow_next_s;
      end
   end
`else
   logic unused_irq_s;
   assign unused_irq_s = irq_save ^ irq_restore;
   assign flags_next_s = w_flags_s;
`endif

   // D stage, flags and W stage registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rst_q_r     <= 1'b1;
         alu_instr_r <= INSTR_NONE;
         sub_r       <= 1'b0;
         subc_r      <= 1'b0;
         addc_r      <= 1'b0;
         cmp_r       <= 1'b0;
         imi_instr_r <= 1'b0;
         imi_data_r  <= 8'h00;
         flags_r     <= FLAG_RESET;
         wb_en_r     <= 1'b0;
         wb_addr_r   <= '0;
         wb_data_r   <= 8'h00;
      end else begin
         rst_q_r <= 1'b0;
         flags_r <= flags_next_s;
         if (hold) begin
            wb_en_r <= 1'b0;
         end else begin
            if (d_load_s) begin
               alu_instr_r <= instr;
               sub_r       <= dec_sub_s;
               subc_r      <= dec_subc_s;
               addc_r      <= dec_addc_s;
               cmp_r       <= dec_cmp_s;
               imi_instr_r <= dec_imi_s;
               imi_data_r  <= instr[7:0];
            end else begin
               alu_instr_r <= INSTR_NONE;
               sub_r       <= 1'b0;
               subc_r      <= 1'b0;
               addc_r      <= 1'b0;
               cmp_r       <= 1'b0;
               imi_instr_r <= 1'b0;
               imi_data_r  <= 8'h00;
            end
            wb_en_r <= d_alu_s & ~d_flag_only_s;
            if (d_alu_s) begin
               wb_data_r <= dout_alu;
               wb_addr_r <= alu_instr_r[8 +: RD_WIDTH];
            end
         end
      end
   end
endmodule

// File: tb/tb_isp8_alu_ctrl.sv
// Scoreboard bench for isp8_alu_ctrl: directed scenarios then randomized traffic
// checked against an instruction-level reference model.
module tb_isp8_alu_ctrl;
   logic        clk;
   logic        rst;
   logic [17:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        hold;
   logic [17:0] alu_instr;
   logic        sub, subc, addc, cmp, imi_instr;
   logic [7:0]  imi_data;
   logic        carry_flag, zero_flag;
   logic [7:0]  dout_alu;
   logic        cout_alu;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [7:0]  wb_data;
   logic        irq_save, irq_restore;

   localparam logic [1:0] FR = 2'b00;

   isp8_alu_ctrl dut (
      .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .hold(hold), .alu_instr(alu_instr),
      .sub(sub), .subc(subc), .addc(addc), .cmp(cmp), .imi_instr(imi_instr),
      .imi_data(imi_data), .carry_flag(carry_flag), .zero_flag(zero_flag),
      .dout_alu(dout_alu), .cout_alu(cout_alu), .wb_en(wb_en), .wb_addr(wb_addr),
      .wb_data(wb_data), .irq_save(irq_save), .irq_restore(irq_restore)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: the instruction currently in D, the flags, the shadow,
   // and a queue of writebacks that the DUT owes us.
   logic        m_ok = 1'b0;
   logic        m_rstq, m_dv;
   logic [17:0] m_di;
   logic [1:0]  m_flags, m_shadow, nf;
   logic [12:0] exp_wb[$];

   function automatic logic [30:0] exp_ctrl(input logic v, input logic [17:0] i);
      int c;
      logic s, sc, ac, cp, im;
      c  = int'(i[17:14]);
      s  = (c == 0);
      sc = (c == 1);
      ac = (c == 3);
      cp = (c == 8);
      im = (c <= 9) ? i[13] : 1'b0;
      if (!v) return {18'h3FFFF, 5'b00000, 8'h00};
      return {i, s, sc, ac, cp, im, i[7:0]};
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_ok = 1'b1; m_rstq = 1'b1; m_dv = 1'b0;
         m_flags = FR; m_shadow = FR;
         exp_wb.delete();
      end else if (m_ok) begin
         if (!hold) begin
            nf = m_flags;
            if (m_dv && int'(m_di[17:14]) < 12) begin
               nf = {dout_alu == 8'h00, cout_alu};
               if (!(int'(m_di[17:14]) == 8 || int'(m_di[17:14]) == 9))
                  exp_wb.push_back({m_di[12:8], dout_alu});
            end
`ifdef ISP8_FLAG_SHADOW_EN
            if (irq_restore) nf = m_shadow;
            else if (irq_save) m_shadow = nf;
`endif
            m_flags = nf;
            if (instr_valid && !m_rstq) begin
               m_dv = 1'b1; m_di = instr;
            end else begin
               m_dv = 1'b0;
            end
         end
         m_rstq = 1'b0;
      end
   end

   // Monitor: compare every cycle; pop the scoreboard whenever a writeback is due.
   always @(negedge clk) begin
      logic [12:0] e;
      if (m_ok) begin
         chk("ctrl", {alu_instr, sub, subc, addc, cmp, imi_instr, imi_data}, exp_ctrl(m_dv, m_di));
         chk("instr_ready", instr_ready, !m_rstq && !hold);
         chk("flags", {zero_flag, carry_flag}, m_flags);
         chk("wb_en", wb_en, exp_wb.size() != 0);
         if (exp_wb.size() != 0) begin
            e = exp_wb.pop_front();
            if (wb_en) chk("wb_addr_data", {wb_addr, wb_data}, e);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst = 1'b1; instr_valid = 1'b1; instr = 18'h00000; hold = 1'b0;
      dout_alu = 8'h00; cout_alu = 1'b0; irq_save = 1'b0; irq_restore = 1'b0;
      repeat (3) cyc();
      chk("reset_state", {instr_ready, wb_en, zero_flag, carry_flag}, 4'b0000);
      rst = 1'b0; instr_valid = 1'b0;
      cyc();
      chk("ready_after_reset", instr_ready, 1'b1);

      // add r1,#1 ; ALU returns 0 with carry out; addc r2 follows with no bubble
      instr = {4'b0010, 1'b1, 5'd1, 8'h01}; instr_valid = 1'b1;
      cyc();
      chk("add_ctrl", {sub, subc, addc, cmp, imi_instr, imi_data}, {5'b00001, 8'h01});
      instr = {4'b0011, 1'b0, 5'd2, 8'h00};
      dout_alu = 8'h00; cout_alu = 1'b1;
      cyc();
      chk("add_wb", {wb_en, wb_addr, wb_data, zero_flag, carry_flag}, {1'b1, 5'd1, 8'h00, 2'b11});
      chk("addc_sees_carry", {addc, carry_flag}, 2'b11);

      // cmp: flags only
      instr = {4'b1000, 1'b1, 5'd3, 8'h07};
      dout_alu = 8'h10; cout_alu = 1'b0;
      cyc();
      chk("cmp_ctrl", {cmp, sub}, 2'b10);
      instr_valid = 1'b0; dout_alu = 8'h05; cout_alu = 1'b0;
      cyc();
      chk("cmp_result", {wb_en, zero_flag, carry_flag}, 3'b000);

      // xor held in D for two edges
      instr = {4'b0111, 1'b0, 5'd4, 8'h00}; instr_valid = 1'b1;
      cyc();
      instr_valid = 1'b0; hold = 1'b1; dout_alu = 8'hA5; cout_alu = 1'b0;
      cyc();
      chk("hold_wb_off", {wb_en, alu_instr}, {1'b0, 4'b0111, 1'b0, 5'd4, 8'h00});
      cyc();
      chk("hold_wb_off2", {wb_en, alu_instr}, {1'b0, 4'b0111, 1'b0, 5'd4, 8'h00});
      hold = 1'b0;
      cyc();
      chk("hold_release_wb", {wb_en, wb_addr, wb_data}, {1'b1, 5'd4, 8'hA5});
      cyc();
      chk("hold_wb_once", wb_en, 1'b0);

      // shadow: flags 11, save, clear to 00, restore on same edge as W update to 01
      instr = {4'b0010, 1'b0, 5'd5, 8'h00}; instr_valid = 1'b1;
      cyc();
      instr_valid = 1'b0; dout_alu = 8'h00; cout_alu = 1'b1;
      cyc();
      irq_save = 1'b1;
      cyc();
      irq_save = 1'b0; instr_valid = 1'b1;
      cyc();
      instr_valid = 1'b0; dout_alu = 8'h03; cout_alu = 1'b0;
      cyc();
      chk("flags_cleared", {zero_flag, carry_flag}, 2'b00);
      instr_valid = 1'b1;
      cyc();
      instr_valid = 1'b0; dout_alu = 8'h07; cout_alu = 1'b1; irq_restore = 1'b1;
      cyc();
      irq_restore = 1'b0;
`ifdef ISP8_FLAG_SHADOW_EN
      chk("shadow_restore", {zero_flag, carry_flag}, 2'b11);
`else
      chk("shadow_restore", {zero_flag, carry_flag}, 2'b01);
`endif

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         rst         = ($urandom_range(0, 99) == 0);
         hold        = ($urandom_range(0, 4) == 0);
         instr_valid = ($urandom_range(0, 2) != 0);
         instr       = 18'($urandom);
         dout_alu    = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         cout_alu    = 1'($urandom);
         irq_save    = ($urandom_range(0, 9) == 0);
         irq_restore = ($urandom_range(0, 9) == 0);
         cyc();
      end
      rst = 1'b0; hold = 1'b0; instr_valid = 1'b0; irq_save = 1'b0; irq_restore = 1'b0;
      repeat (4) cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
